// File: rtl/mult_ctrl_fsm.sv
// Control unit for the 8-bit shift-and-add accumulator multiplier.
// Sequences operand loads, N accumulate-and-shift iterations and a done pulse.
module mult_ctrl_fsm #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_valid,
  input  logic i_A_lsb,
  output logic o_ready,
  output logic load_A,
  output logic load_B,
  output logic clr_ACC_reg,
  output logic load_ACC,
  output logic sel_SUM,
  output logic shift_A_reg,
  output logic o_busy,
  output logic o_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ITER   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;

  // The counter counts iterations remaining; a zero count in ITER is a
  // corrupted state, so bail out to IDLE rather than wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) state <= LOAD_A;
        end
        LOAD_A: begin
          if (i_valid) state <= LOAD_B;
        end
        LOAD_B: begin
          if (i_valid) begin
            state <= ITER;
            cnt   <= CNT_W'(N);
          end
        end
        ITER: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are Mealy: load strobes follow i_valid and the add/pass select
  // follows the live multiplicand LSB in the same cycle.
  always_comb begin
    o_ready     = 1'b0;
    load_A      = 1'b0;
    load_B      = 1'b0;
    clr_ACC_reg = 1'b0;
    load_ACC    = 1'b0;
    sel_SUM     = 1'b0;
    shift_A_reg = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state)
      LOAD_A: begin
        o_busy      = 1'b1;
        o_ready     = 1'b1;
        clr_ACC_reg = 1'b1;
        load_A      = i_valid;
      end
      LOAD_B: begin
        o_busy  = 1'b1;
        o_ready = 1'b1;
        load_B  = i_valid;
      end
      ITER: begin
        o_busy      = 1'b1;
        load_ACC    = 1'b1;
        shift_A_reg = 1'b1;
        sel_SUM     = i_A_lsb;
      end
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Self-checking bench for mult_ctrl_fsm: drives it against a behavioural
// shift-and-add datapath and checks control timing and products against a*b.
module tb_mult_ctrl_fsm;

  logic i_clk = 1'b0;
  logic i_rst, i_start, i_valid, i_A_lsb;
  logic o_ready, load_A, load_B, clr_ACC_reg, load_ACC, sel_SUM, shift_A_reg, o_busy, o_done;
  logic [7:0] data_in, dp_a, dp_b, dp_acc;
  logic [8:0] dp_sum;
  logic [8:0] ctrl;
  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  mult_ctrl_fsm dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_valid    (i_valid),
    .i_A_lsb    (i_A_lsb),
    .o_ready    (o_ready),
    .load_A     (load_A),
    .load_B     (load_B),
    .clr_ACC_reg(clr_ACC_reg),
    .load_ACC   (load_ACC),
    .sel_SUM    (sel_SUM),
    .shift_A_reg(shift_A_reg),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  assign ctrl = {o_ready, o_busy, load_A, load_B, clr_ACC_reg, load_ACC, sel_SUM, shift_A_reg, o_done};

  // Datapath stand-in: {carry, ACC, A} shifts right after an optional add of B.
  assign i_A_lsb = dp_a[0];
  assign dp_sum  = sel_SUM ? ({1'b0, dp_acc} + {1'b0, dp_b}) : {1'b0, dp_acc};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dp_acc <= '0;
      dp_a   <= '0;
      dp_b   <= '0;
    end else begin
      if (clr_ACC_reg) dp_acc <= '0;
      if (load_A) dp_a <= data_in;
      if (load_B) dp_b <= data_in;
      if (load_ACC) dp_acc <= dp_sum[8:1];
      if (shift_A_reg) dp_a <= {dp_sum[0], dp_a[7:1]};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Expected {ready,busy,ldA,ldB,clr,ldACC,sel,shift,done} per phase:
  // 0 idle, 1 loading A, 2 loading B, 3 iterating, 4 done.
  function automatic logic [8:0] expCtrl(input int phase, input logic v, input logic s);
    case (phase)
      1:       return {1'b1, 1'b1, v, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      2:       return {1'b1, 1'b1, 1'b0, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      3:       return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, s, 1'b1, 1'b0};
      4:       return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      default: return 9'd0;
    endcase
  endfunction

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      i_valid = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      #1;
      checkOutput($sformatf("idle_c%0d", k), ctrl, 0);
    end
    i_valid = 1'b0;
  endtask

  // One multiply: start in cycle 0, operand stalls, optional junk on i_start
  // and i_valid after the loads, optional async reset after cycle abort_at.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int stall_a,
                               input int stall_b, input bit spurious, input int abort_at);
    int total;
    int acc_cycles;
    total      = 11 + stall_a + stall_b;
    acc_cycles = 0;
    for (int k = 0; k <= total; k++) begin
      int phase;
      int iter_idx;
      logic v;
      logic s;
      @(negedge i_clk);
      if (k == 0) phase = 0;
      else if (k <= 1 + stall_a) phase = 1;
      else if (k <= 2 + stall_a + stall_b) phase = 2;
      else if (k < total) phase = 3;
      else phase = 4;
      iter_idx = k - (3 + stall_a + stall_b);
      i_start  = (k == 0) ? 1'b1 : (spurious ? 1'($urandom_range(0, 1)) : 1'b0);
      v        = 1'b0;
      s        = 1'b0;
      data_in  = 8'($urandom);
      case (phase)
        1: begin v = (k == 1 + stall_a); data_in = a; end
        2: begin v = (k == 2 + stall_a + stall_b); data_in = b; end
        3: begin v = spurious ? 1'($urandom_range(0, 1)) : 1'b0; s = a[iter_idx]; end
        4: v = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        default: v = 1'b0;
      endcase
      i_valid = v;
      #1;
      checkOutput($sformatf("ctrl_c%0d", k), ctrl, expCtrl(phase, v, s));
      if (load_ACC) acc_cycles++;
      if (phase == 4)
        checkOutput($sformatf("product_%0d_x_%0d", a, b), {dp_acc, dp_a}, int'(a) * int'(b));
      if (k == abort_at) begin
        i_start = 1'b0;
        i_valid = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("rst_async", ctrl, 0);
        @(posedge i_clk);
        #1;
        checkOutput("rst_held", ctrl, 0);
        i_rst = 1'b0;
        return;
      end
    end
    checkOutput("acc_cycles", acc_cycles, 8);
    i_start = 1'b0;
    i_valid = 1'b0;
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    data_in = '0;
    #12;
    checkOutput("reset_ctrl", ctrl, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    idleCycles(4);

    applyStimulus(8'h0D, 8'h0B, 0, 0, 1'b0, -1);
    applyStimulus(8'hFF, 8'hFF, 0, 0, 1'b0, -1);
    applyStimulus(8'h00, 8'h5A, 0, 0, 1'b0, -1);
    applyStimulus(8'h0D, 8'h0B, 3, 2, 1'b0, -1);
    applyStimulus(8'hC8, 8'h25, 0, 0, 1'b1, -1);
    idleCycles(2);
    applyStimulus(8'h77, 8'h99, 0, 0, 1'b0, 6);
    idleCycles(3);
    applyStimulus(8'h03, 8'h05, 0, 0, 1'b0, -1);

    for (int n = 0; n < 20; n++) begin
      applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 2) == 0) idleCycles(1);
    end
    idleCycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
